de0_hmsclock: RTL and testbench



---
 rtl/de0_hmsclock.sv | 248 ++++++++++++++++++++++++
 tb/tb_de0_hmsclock.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/de0_hmsclock.sv
`default_nettype none
// ============================================================================
// Module   : de0_hmsclock
// Purpose  : HH:MM:SS clock for the DE0 board. A parametrised prescaler makes
//            a 1 Hz tick. Time runs in 24-hour or 12-hour (AM/PM) mode.
//            MODE/INC buttons drive a RUN -> SET_HOUR -> SET_MIN -> RUN
//            setting FSM. While a field is being set, it blinks.
// Ports    : CLK        - system clock, rising edge
//            nRST       - asynchronous active-low reset
//            nBTN_MODE  - mode button, active-low, debounced, async to CLK
//            nBTN_INC   - increment button, active-low, debounced, async
//            DISP_SEL   - in RUN: 0 = MM:SS, 1 = HH:MM
//            TICK       - one-cycle pulse at prescaler wrap
//            PM         - PM indicator
//            nSEG0..3   - active-low gfedcba digits, nSEG3 leftmost
// Revision : 1.0 - initial release
// ============================================================================
module de0_hmsclock #(
  parameter int CLK_HZ = 50_000_000,
  parameter int HOUR24 = 1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       nBTN_MODE,
  input  logic       nBTN_INC,
  input  logic       DISP_SEL,
  output logic       TICK,
  output logic       PM,
  output logic [6:0] nSEG0,
  output logic [6:0] nSEG1,
  output logic [6:0] nSEG2,
  output logic [6:0] nSEG3
);

  localparam int               CNT_W     = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_HZ / 2);
  localparam logic [6:0]       SEG_BLANK = 7'b111_1111;
  localparam logic [6:0]       SEG_ZERO  = 7'b100_0000;
  localparam logic [1:0]       HR_T_RST  = (HOUR24 != 0) ? 2'd0 : 2'd1;
  localparam logic [3:0]       HR_U_RST  = (HOUR24 != 0) ? 4'd0 : 4'd2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b100_0000;
      4'd1:    seg7 = 7'b111_1001;
      4'd2:    seg7 = 7'b010_0100;
      4'd3:    seg7 = 7'b011_0000;
      4'd4:    seg7 = 7'b001_1001;
      4'd5:    seg7 = 7'b001_0010;
      4'd6:    seg7 = 7'b000_0010;
      4'd7:    seg7 = 7'b111_1000;
      4'd8:    seg7 = 7'b000_0000;
      4'd9:    seg7 = 7'b001_0000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Registers
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [2:0]       mode_sync_q, mode_sync_d;   // [0],[1] synchronizer, [2] edge history
  logic [2:0]       inc_sync_q, inc_sync_d;
  logic [3:0]       sec_u_q, sec_u_d;
  logic [2:0]       sec_t_q, sec_t_d;
  logic [3:0]       min_u_q, min_u_d;
  logic [2:0]       min_t_q, min_t_d;
  logic [3:0]       hr_u_q, hr_u_d;
  logic [1:0]       hr_t_q, hr_t_d;
  logic             pm_q, pm_d;                 // AM/PM flag, 12-hour mode only
  logic [6:0]       seg0_q, seg0_d, seg1_q, seg1_d, seg2_q, seg2_d, seg3_q, seg3_d;

  // Combinational helpers
  logic       tick_w, blink_w, mode_press_w, inc_press_w;
  logic       sec_wrap_w, min_wrap_w, pm_flip_w;
  logic [3:0] hr_inc_u_w, min_inc_u_w, sec_inc_u_w;
  logic [1:0] hr_inc_t_w;
  logic [2:0] min_inc_t_w, sec_inc_t_w;
  logic [6:0] ht_w, hu_w, mt_w, mu_w, st_w, su_w;

  assign tick_w       = (cnt_q == CNT_LAST);
  assign blink_w      = (cnt_q >= CNT_HALF);
  assign mode_press_w = mode_sync_q[2] & ~mode_sync_q[1];
  assign inc_press_w  = inc_sync_q[2] & ~inc_sync_q[1];

  assign TICK  = tick_w;
  assign PM    = (HOUR24 != 0) ? ((hr_t_q == 2'd2) || (hr_t_q == 2'd1 && hr_u_q >= 4'd2))
                               : pm_q;
  assign nSEG0 = seg0_q;
  assign nSEG1 = seg1_q;
  assign nSEG2 = seg2_q;
  assign nSEG3 = seg3_q;

  // BCD increments of each field, shared by ticking and by button setting
  always_comb begin
    sec_wrap_w  = (sec_t_q == 3'd5) && (sec_u_q == 4'd9);
    sec_inc_u_w = (sec_u_q == 4'd9) ? 4'd0 : sec_u_q + 4'd1;
    sec_inc_t_w = (sec_u_q != 4'd9) ? sec_t_q : (sec_wrap_w ? 3'd0 : sec_t_q + 3'd1);

    min_wrap_w  = (min_t_q == 3'd5) && (min_u_q == 4'd9);
    min_inc_u_w = (min_u_q == 4'd9) ? 4'd0 : min_u_q + 4'd1;
    min_inc_t_w = (min_u_q != 4'd9) ? min_t_q : (min_wrap_w ? 3'd0 : min_t_q + 3'd1);

    hr_inc_t_w = hr_t_q;
    hr_inc_u_w = hr_u_q + 4'd1;
    pm_flip_w  = 1'b0;
    if (HOUR24 != 0) begin
      if (hr_t_q == 2'd2 && hr_u_q == 4'd3) begin
        hr_inc_t_w = 2'd0;
        hr_inc_u_w = 4'd0;
      end else if (hr_u_q == 4'd9) begin
        hr_inc_t_w = hr_t_q + 2'd1;
        hr_inc_u_w = 4'd0;
      end
    end else begin
      if (hr_t_q == 2'd1 && hr_u_q == 4'd2) begin
        hr_inc_t_w = 2'd0;
        hr_inc_u_w = 4'd1;
      end else if (hr_t_q == 2'd1 && hr_u_q == 4'd1) begin
        pm_flip_w = 1'b1;                 // 11 -> 12 crosses noon/midnight
      end else if (hr_u_q == 4'd9) begin
        hr_inc_t_w = 2'd1;
        hr_inc_u_w = 4'd0;
      end
    end
  end

  // FSM and time next-state
  always_comb begin
    state_d     = state_q;
    cnt_d       = tick_w ? '0 : cnt_q + CNT_W'(1);
    mode_sync_d = {mode_sync_q[1:0], nBTN_MODE};
    inc_sync_d  = {inc_sync_q[1:0], nBTN_INC};
    sec_u_d     = sec_u_q;
    sec_t_d     = sec_t_q;
    min_u_d     = min_u_q;
    min_t_d     = min_t_q;
    hr_u_d      = hr_u_q;
    hr_t_d      = hr_t_q;
    pm_d        = pm_q;

    // MODE has priority over INC and over a coincident tick
    if (mode_press_w) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        default: begin
          state_d = RUN;
          sec_u_d = 4'd0;
          sec_t_d = 3'd0;
          cnt_d   = '0;                   // restart the second on exit
        end
      endcase
    end else if (inc_press_w && state_q == SET_HOUR) begin
      hr_u_d = hr_inc_u_w;
      hr_t_d = hr_inc_t_w;
      pm_d   = pm_q ^ pm_flip_w;
    end else if (inc_press_w && state_q == SET_MIN) begin
      min_u_d = min_inc_u_w;
      min_t_d = min_inc_t_w;
    end else if (state_q == RUN && tick_w) begin
      sec_u_d = sec_inc_u_w;
      sec_t_d = sec_inc_t_w;
      if (sec_wrap_w) begin
        min_u_d = min_inc_u_w;
        min_t_d = min_inc_t_w;
        if (min_wrap_w) begin
          hr_u_d = hr_inc_u_w;
          hr_t_d = hr_inc_t_w;
          pm_d   = pm_q ^ pm_flip_w;
        end
      end
    end
  end

  // Display next-state
  always_comb begin
    ht_w = ((HOUR24 == 0) && (hr_t_q == 2'd0)) ? SEG_BLANK : seg7({2'b00, hr_t_q});
    hu_w = seg7(hr_u_q);
    mt_w = seg7({1'b0, min_t_q});
    mu_w = seg7(min_u_q);
    st_w = seg7({1'b0, sec_t_q});
    su_w = seg7(sec_u_q);
    if (state_q == SET_HOUR && blink_w) begin
      ht_w = SEG_BLANK;
      hu_w = SEG_BLANK;
    end
    if (state_q == SET_MIN && blink_w) begin
      mt_w = SEG_BLANK;
      mu_w = SEG_BLANK;
    end
    if (state_q == RUN && !DISP_SEL) begin
      seg3_d = mt_w;
      seg2_d = mu_w;
      seg1_d = st_w;
      seg0_d = su_w;
    end else begin
      seg3_d = ht_w;
      seg2_d = hu_w;
      seg1_d = mt_w;
      seg0_d = mu_w;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q       <= '0;
      state_q     <= RUN;
      mode_sync_q <= 3'b111;
      inc_sync_q  <= 3'b111;
      sec_u_q     <= 4'd0;
      sec_t_q     <= 3'd0;
      min_u_q     <= 4'd0;
      min_t_q     <= 3'd0;
      hr_u_q      <= HR_U_RST;
      hr_t_q      <= HR_T_RST;
      pm_q        <= 1'b0;
      seg0_q      <= SEG_ZERO;
      seg1_q      <= SEG_ZERO;
      seg2_q      <= SEG_ZERO;
      seg3_q      <= SEG_ZERO;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      mode_sync_q <= mode_sync_d;
      inc_sync_q  <= inc_sync_d;
      sec_u_q     <= sec_u_d;
      sec_t_q     <= sec_t_d;
      min_u_q     <= min_u_d;
      min_t_q     <= min_t_d;
      hr_u_q      <= hr_u_d;
      hr_t_q      <= hr_t_d;
      pm_q        <= pm_d;
      seg0_q      <= seg0_d;
      seg1_q      <= seg1_d;
      seg2_q      <= seg2_d;
      seg3_q      <= seg3_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_de0_hmsclock.sv
`default_nettype none
// ============================================================================
// Module   : tb_de0_hmsclock
// Purpose  : Bench for de0_hmsclock. A 24-hour and a 12-hour instance share
//            the same stimulus. Each instance is compared every cycle against
//            a seconds-of-day reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_de0_hmsclock;

  localparam int CLK_HZ = 4;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       nBTN_MODE = 1'b1;
  logic       nBTN_INC = 1'b1;
  logic       DISP_SEL = 1'b0;
  logic       tick24, tick12, pm24, pm12;
  logic [6:0] s24 [4];
  logic [6:0] s12 [4];

  int nvec = 0;
  int nfail = 0;

  always #5 CLK = ~CLK;

  de0_hmsclock #(.CLK_HZ(CLK_HZ), .HOUR24(1)) u_dut24 (
    .CLK(CLK), .nRST(nRST), .nBTN_MODE(nBTN_MODE), .nBTN_INC(nBTN_INC),
    .DISP_SEL(DISP_SEL), .TICK(tick24), .PM(pm24),
    .nSEG0(s24[0]), .nSEG1(s24[1]), .nSEG2(s24[2]), .nSEG3(s24[3])
  );

  de0_hmsclock #(.CLK_HZ(CLK_HZ), .HOUR24(0)) u_dut12 (
    .CLK(CLK), .nRST(nRST), .nBTN_MODE(nBTN_MODE), .nBTN_INC(nBTN_INC),
    .DISP_SEL(DISP_SEL), .TICK(tick12), .PM(pm12),
    .nSEG0(s12[0]), .nSEG1(s12[1]), .nSEG2(s12[2]), .nSEG3(s12[3])
  );

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [6:0] segc(input int d);
    case (d)
      0: segc = 7'b100_0000;  1: segc = 7'b111_1001;
      2: segc = 7'b010_0100;  3: segc = 7'b011_0000;
      4: segc = 7'b001_1001;  5: segc = 7'b001_0010;
      6: segc = 7'b000_0010;  7: segc = 7'b111_1000;
      8: segc = 7'b000_0000;  9: segc = 7'b001_0000;
      default: segc = 7'b111_1111;
    endcase
  endfunction

  // Returns {nSEG3, nSEG2, nSEG1, nSEG0} for a given time-of-day (seconds).
  function automatic logic [27:0] disp(input int st, input int t, input bit ds,
                                       input bit bl, input bit h24);
    int h, m, s, hd;
    logic [6:0] ht, hu, mt, mu, sx, su;
    h  = t / 3600;
    m  = (t / 60) % 60;
    s  = t % 60;
    hd = h24 ? h : ((h % 12 == 0) ? 12 : h % 12);
    ht = (!h24 && hd / 10 == 0) ? 7'h7F : segc(hd / 10);
    hu = segc(hd % 10);
    mt = segc(m / 10);
    mu = segc(m % 10);
    sx = segc(s / 10);
    su = segc(s % 10);
    if (st == 1 && bl) begin ht = 7'h7F; hu = 7'h7F; end
    if (st == 2 && bl) begin mt = 7'h7F; mu = 7'h7F; end
    if (st == 0 && !ds) disp = {mt, mu, sx, su};
    else                disp = {ht, hu, mt, mu};
  endfunction

  int         m_cnt = 0;
  int         m_state = 0;           // 0 run, 1 set hour, 2 set minute
  int         m_t = 0;               // seconds since midnight (12:00 AM = 0)
  logic [2:0] hist_mode = 3'b111;    // pin samples, [0] = most recent edge
  logic [2:0] hist_inc = 3'b111;
  logic [27:0] e24 = {4{7'h40}};
  logic [27:0] e12 = {4{7'h40}};

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_cnt = 0; m_state = 0; m_t = 0;
      hist_mode = 3'b111; hist_inc = 3'b111;
      e24 = {4{7'h40}}; e12 = {4{7'h40}};
    end else begin
      bit pmode, pinc, tk, bl, ex;
      int h, mn;
      // A pin that fell is acted upon at the third clock edge that sees it low
      pmode = hist_mode[2] & ~hist_mode[1];
      pinc  = hist_inc[2] & ~hist_inc[1];
      tk    = (m_cnt == CLK_HZ - 1);
      bl    = (m_cnt >= CLK_HZ / 2);
      e24   = disp(m_state, m_t, DISP_SEL, bl, 1'b1);
      e12   = disp(m_state, m_t, DISP_SEL, bl, 1'b0);
      ex    = 1'b0;
      h     = m_t / 3600;
      mn    = (m_t / 60) % 60;
      if (pmode) begin
        if (m_state == 2) begin
          m_t = m_t - m_t % 60;
          m_state = 0;
          ex = 1'b1;
        end else begin
          m_state++;
        end
      end else if (pinc && m_state == 1) begin
        m_t = m_t + (((h + 1) % 24) - h) * 3600;
      end else if (pinc && m_state == 2) begin
        m_t = m_t + (((mn + 1) % 60) - mn) * 60;
      end else if (m_state == 0 && tk) begin
        m_t = (m_t + 1) % 86400;
      end
      m_cnt     = (ex || tk) ? 0 : m_cnt + 1;
      hist_mode = {hist_mode[1:0], nBTN_MODE};
      hist_inc  = {hist_inc[1:0], nBTN_INC};
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge CLK) begin
    if (nRST) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("nSEG%0d_h24", i), s24[i], e24[7*i +: 7]);
        check($sformatf("nSEG%0d_h12", i), s12[i], e12[7*i +: 7]);
      end
      check("TICK_h24", tick24, (m_cnt == CLK_HZ - 1) ? 1 : 0);
      check("TICK_h12", tick12, (m_cnt == CLK_HZ - 1) ? 1 : 0);
      check("PM_h24", pm24, (m_t >= 43200) ? 1 : 0);
      check("PM_h12", pm12, (m_t >= 43200) ? 1 : 0);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic press(input bit do_mode, input bit do_inc, input int hold);
    @(negedge CLK);
    if (do_mode) nBTN_MODE = 1'b0;
    if (do_inc)  nBTN_INC  = 1'b0;
    repeat (hold) @(negedge CLK);
    nBTN_MODE = 1'b1;
    nBTN_INC  = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic lit4(input string name, input logic [6:0] a3, input logic [6:0] a2,
                      input logic [6:0] a1, input logic [6:0] a0, input logic [27:0] exp);
    check({name, "_d3"}, a3, exp[27:21]);
    check({name, "_d2"}, a2, exp[20:14]);
    check({name, "_d1"}, a1, exp[13:7]);
    check({name, "_d0"}, a0, exp[6:0]);
  endtask

  initial begin
    int mc, ic;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // First tick shows seconds = 01
    repeat (5) @(negedge CLK);
    check("lit_first_second", s24[0], 7'b111_1001);

    // Asynchronous reset takes effect without a clock edge
    #1 nRST = 1'b0;
    #1;
    check("lit_async_rst_d0", s24[0], 7'b100_0000);
    check("lit_async_rst_d3", s24[3], 7'b100_0000);
    check("lit_async_rst_h12", s12[1], 7'b100_0000);
    check("lit_async_rst_tick", tick24, 0);

    // Carry chain: 3599 s then 3600 s, HH:MM view
    DISP_SEL = 1'b1;
    @(negedge CLK);
    nRST = 1'b1;
    repeat (14400) @(negedge CLK);
    lit4("lit_0059_h24", s24[3], s24[2], s24[1], s24[0], {7'h40, 7'h40, 7'h12, 7'h10});
    lit4("lit_1259_h12", s12[3], s12[2], s12[1], s12[0], {7'h79, 7'h24, 7'h12, 7'h10});
    @(negedge CLK);
    lit4("lit_0100_h24", s24[3], s24[2], s24[1], s24[0], {7'h40, 7'h79, 7'h40, 7'h40});
    lit4("lit_0100_h12", s12[3], s12[2], s12[1], s12[0], {7'h7F, 7'h79, 7'h40, 7'h40});

    // Set 23:59 from reset, exit, then run across midnight
    do_reset();
    press(1'b1, 1'b0, 1);
    repeat (23) press(1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1);
    repeat (59) press(1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1);
    lit4("lit_2359_h24", s24[3], s24[2], s24[1], s24[0], {7'h24, 7'h30, 7'h12, 7'h10});
    lit4("lit_1159_h12", s12[3], s12[2], s12[1], s12[0], {7'h79, 7'h79, 7'h12, 7'h10});
    check("lit_pm_before", pm24, 1);
    repeat (240) @(negedge CLK);
    lit4("lit_0000_h24", s24[3], s24[2], s24[1], s24[0], {7'h40, 7'h40, 7'h40, 7'h40});
    lit4("lit_1200_h12", s12[3], s12[2], s12[1], s12[0], {7'h79, 7'h24, 7'h40, 7'h40});
    check("lit_pm_after", pm24, 0);

    // Simultaneous MODE+INC, held INC, and a full 24-step hour loop
    press(1'b1, 1'b0, 1);
    press(1'b1, 1'b1, 1);
    press(1'b0, 1'b1, 10);
    press(1'b1, 1'b0, 1);
    press(1'b1, 1'b0, 1);
    repeat (24) press(1'b0, 1'b1, 2);
    press(1'b1, 1'b0, 1);
    press(1'b1, 1'b0, 1);

    // Random button activity and display selection
    mc = 0;
    ic = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      if (mc == 0) begin
        nBTN_MODE = 1'b1;
        if ($urandom_range(0, 29) == 0) mc = $urandom_range(1, 6);
      end else begin
        nBTN_MODE = 1'b0;
        mc--;
      end
      if (ic == 0) begin
        nBTN_INC = 1'b1;
        if ($urandom_range(0, 7) == 0) ic = $urandom_range(1, 6);
      end else begin
        nBTN_INC = 1'b0;
        ic--;
      end
      if ($urandom_range(0, 15) == 0) DISP_SEL = ~DISP_SEL;
    end
    nBTN_MODE = 1'b1;
    nBTN_INC  = 1'b1;
    repeat (10) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
